// File: rtl/floating_point.sv
// Multi-cycle IEEE-754 single conversion unit (custom-instruction style).
// Optional int->float datapath: define FP_ITOF_EN to build it.
module floating_point #(
  parameter int LATENCY = 3,
  parameter int N_W     = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clk_en,
  input  logic           reset_req,
  input  logic           start,
  input  logic [N_W-1:0] n,
  input  logic [31:0]    dataa,
  input  logic [31:0]    datab,
  output logic           done,
  output logic [31:0]    result
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t         state;
  logic [3:0]     cnt;
  logic [31:0]    a_q;
  logic [N_W-1:0] op_q;
  logic [31:0]    op_res;

  logic           fi_s;
  logic [7:0]     fi_e;
  logic [31:0]    fi_m;
  logic [31:0]    fi_mag;
  logic [31:0]    ftoi;

  // float -> int32, truncating toward zero, saturating out of range
  always_comb begin
    fi_s   = a_q[31];
    fi_e   = a_q[30:23];
    fi_m   = {8'd0, 1'b1, a_q[22:0]};
    fi_mag = '0;
    ftoi   = '0;
    if (fi_e == 8'hFF && a_q[22:0] != 23'd0) begin
      ftoi = 32'h7FFF_FFFF;
    end else if (fi_e >= 8'd158) begin
      ftoi = fi_s ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else if (fi_e >= 8'd150) begin
      fi_mag = fi_m << (fi_e - 8'd150);
      ftoi   = fi_s ? -fi_mag : fi_mag;
    end else if (fi_e >= 8'd127) begin
      fi_mag = fi_m >> (8'd150 - fi_e);
      ftoi   = fi_s ? -fi_mag : fi_mag;
    end
  end

`ifdef FP_ITOF_EN
  logic [31:0] if_mag;
  logic [31:0] if_norm;
  logic [4:0]  if_p;
  logic        if_up;
  logic [24:0] if_rnd;
  logic [7:0]  if_exp;
  logic [31:0] itof;

  // int32 -> float, round to nearest even on the 24-bit significand
  always_comb begin
    if_mag = a_q[31] ? (~a_q + 32'd1) : a_q;
    if_p   = '0;
    for (int i = 0; i < 32; i++) begin
      if (if_mag[i]) if_p = 5'(i);
    end
    if_norm = if_mag << (5'd31 - if_p);
    if_up   = if_norm[7] &
              ((|if_norm[6:0]) | if_norm[8]);
    if_rnd  = {1'b0, if_norm[31:8]} +
              {24'd0, if_up};
    if_exp  = 8'd127 + {3'd0, if_p} +
              {7'd0, if_rnd[24]};
    itof    = {a_q[31], if_exp, if_rnd[22:0]};
    if (a_q == 32'd0) itof = '0;
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, datab, if_rnd[23]};
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, datab};
`endif

  // operation decode on the latched opcode
  always_comb begin
    op_res = '0;
    unique case (1'b1)
      (op_q == N_W'(1)): op_res = ftoi;
`ifdef FP_ITOF_EN
      (op_q == N_W'(0)): op_res = itof;
`endif
      default: op_res = '0;
    endcase
  end

  // control FSM: latch on start, count enabled edges, pulse done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      done   <= 1'b0;
      result <= '0;
      a_q    <= '0;
      op_q   <= '0;
    end else if (clk_en) begin
      done <= 1'b0;
      if (reset_req) begin
        state  <= IDLE;
        cnt    <= '0;
        result <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              a_q   <= dataa;
              op_q  <= n;
              cnt   <= 4'd1;
              state <= BUSY;
            end
          end
          BUSY: begin
            if (cnt == 4'(LATENCY)) begin
              done   <= 1'b1;
              result <= op_res;
              cnt    <= '0;
              state  <= IDLE;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_floating_point.sv
// Self-checking bench for floating_point.
// Reference model uses real arithmetic, independent of the RTL datapath.
module tb_floating_point;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b1;
  logic        reset_req = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  n = '0;
  logic [31:0] dataa = '0;
  logic [31:0] datab = '0;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  floating_point #(
    .LATENCY(LAT),
    .N_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clk_en(clk_en),
    .reset_req(reset_req),
    .start(start),
    .n(n),
    .dataa(dataa),
    .datab(datab),
    .done(done),
    .result(result)
  );

  function automatic logic [31:0] m_ftoi(
    input logic [31:0] a
  );
    int  e;
    real v;
    e = int'(a[30:23]);
    if (e == 255 && a[22:0] != 23'd0)
      return 32'h7FFF_FFFF;
    v = real'({1'b1, a[22:0]}) * (2.0 ** (e - 150));
    if (a[31]) v = -v;
    if (v >= 2147483648.0) return 32'h7FFF_FFFF;
    if (v < -2147483648.0) return 32'h8000_0000;
    return 32'($rtoi(v));
  endfunction

  function automatic logic [31:0] m_itof(
    input logic [31:0] a
  );
    longint mag;
    longint f;
    int     p;
    real    q;
    real    fl;
    if (a == 32'd0) return 32'd0;
    mag = longint'($signed(a));
    if (mag < 0) mag = -mag;
    p = 0;
    while ((64'sd1 <<< (p + 1)) <= mag) p++;
    q  = real'(mag) / (2.0 ** (p - 23));
    fl = $floor(q);
    f  = longint'(fl);
    if ((q - fl) > 0.5 || ((q - fl) == 0.5 && f[0]))
      f++;
    if (f == (64'sd1 <<< 24)) begin
      f = f >>> 1;
      p++;
    end
    return {a[31], 8'(127 + p), f[22:0]};
  endfunction

  task automatic run_op(
    input  logic [31:0] a,
    input  logic [7:0]  op,
    output logic [31:0] r,
    output int          cyc
  );
    @(negedge clk);
    dataa = a;
    n     = op;
    datab = $urandom;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    r = result;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (done !== 1'b0 || result !== 32'd0) begin
      failures++;
      $display("FAIL reset: done=%b result=%h want 0/0",
               done, result);
    end
    @(negedge clk);
    start = 1'b1;
    dataa = 32'h3F80_0000;
    n     = 8'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (done !== 1'b0 || result !== 32'd0) begin
      failures++;
      $display("FAIL reset_hold: done=%b result=%h",
               done, result);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ftoi_directed();
    logic [31:0] va [7];
    logic [31:0] ve [7];
    logic [31:0] r;
    int          cyc;
    va = '{32'h3F80_0000, 32'h4049_0FDB, 32'hC2F7_0000,
           32'h3F00_0000, 32'h4F00_0000, 32'hCF80_0000,
           32'h7FC0_0000};
    ve = '{32'h0000_0001, 32'h0000_0003, 32'hFFFF_FF85,
           32'h0000_0000, 32'h7FFF_FFFF, 32'h8000_0000,
           32'h7FFF_FFFF};
    foreach (va[i]) begin
      run_op(va[i], 8'd1, r, cyc);
      checks++;
      if (r !== ve[i] || cyc != LAT + 1) begin
        failures++;
        $display("FAIL ftoi_dir %h: got %h lat %0d want %h lat %0d",
                 va[i], r, cyc, ve[i], LAT + 1);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || result !== ve[6]) begin
      failures++;
      $display("FAIL done_pulse: done=%b result=%h",
               done, result);
    end
  endtask

  task automatic test_ftoi_random();
    logic [31:0] a;
    logic [31:0] r;
    logic [31:0] exp_r;
    int          cyc;
    for (int i = 0; i < 60; i++) begin
      a = {1'($urandom), 8'($urandom_range(110, 170)),
           23'($urandom)};
      if (i % 10 == 9) a[30:23] = 8'hFF;
      if (i % 20 == 19) a[22:0] = '0;
      exp_r = m_ftoi(a);
      run_op(a, 8'd1, r, cyc);
      checks++;
      if (r !== exp_r || cyc != LAT + 1) begin
        failures++;
        $display("FAIL ftoi_rand %h: got %h lat %0d want %h",
                 a, r, cyc, exp_r);
      end
    end
  endtask

  task automatic test_itof();
    logic [31:0] a;
    logic [31:0] r;
    logic [31:0] exp_r;
    int          cyc;
`ifdef FP_ITOF_EN
    logic [31:0] va [5];
    logic [31:0] ve [5];
    va = '{32'h0000_0064, 32'hFFFF_FFFF, 32'h0100_0001,
           32'h8000_0000, 32'h0000_0000};
    ve = '{32'h42C8_0000, 32'hBF80_0000, 32'h4B80_0000,
           32'hCF00_0000, 32'h0000_0000};
    foreach (va[i]) begin
      run_op(va[i], 8'd0, r, cyc);
      checks++;
      if (r !== ve[i] || cyc != LAT + 1) begin
        failures++;
        $display("FAIL itof_dir %h: got %h want %h",
                 va[i], r, ve[i]);
      end
    end
    for (int i = 0; i < 40; i++) begin
      a = $urandom >> $urandom_range(0, 31);
      if (i % 2 == 1) a = -a;
      exp_r = m_itof(a);
      run_op(a, 8'd0, r, cyc);
      checks++;
      if (r !== exp_r) begin
        failures++;
        $display("FAIL itof_rand %h: got %h want %h",
                 a, r, exp_r);
      end
    end
`else
    for (int i = 0; i < 4; i++) begin
      a = $urandom | 32'd1;
      run_op(a, 8'd0, r, cyc);
      checks++;
      if (r !== 32'd0 || cyc != LAT + 1) begin
        failures++;
        $display("FAIL itof_off %h: got %h lat %0d want 0",
                 a, r, cyc);
      end
    end
`endif
  endtask

  task automatic test_other_op();
    logic [7:0]  op;
    logic [31:0] r;
    int          cyc;
    for (int i = 0; i < 6; i++) begin
      op = 8'($urandom_range(2, 255));
      run_op(32'h4049_0FDB, op, r, cyc);
      checks++;
      if (r !== 32'd0 || cyc != LAT + 1) begin
        failures++;
        $display("FAIL other_op n=%0d: got %h lat %0d want 0",
                 op, r, cyc);
      end
    end
  endtask

  task automatic test_clk_en_stall();
    int          cyc;
    logic [31:0] r;
    @(negedge clk);
    dataa = 32'hC2F7_0000;
    n     = 8'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (!done && cyc < 20) begin
      if (cyc == 2) clk_en = 1'b0;
      if (cyc == 4) clk_en = 1'b1;
      @(negedge clk);
      cyc++;
    end
    r = result;
    checks++;
    if (r !== 32'hFFFF_FF85 || cyc != LAT + 3) begin
      failures++;
      $display("FAIL clk_en_stall: got %h lat %0d want %h lat %0d",
               r, cyc, 32'hFFFF_FF85, LAT + 3);
    end
    clk_en = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || result !== 32'hFFFF_FF85) begin
      failures++;
      $display("FAIL clk_en_hold: done=%b result=%h",
               done, result);
    end
    clk_en = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL clk_en_drop: done=%b want 0", done);
    end
  endtask

  task automatic test_busy_start();
    int ndone = 0;
    int first = 0;
    logic [31:0] r = '0;
    @(negedge clk);
    dataa = 32'h4049_0FDB;
    n     = 8'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    dataa = 32'h4F00_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 4; c < 14; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          first = c;
          r = result;
        end
      end
    end
    checks++;
    if (ndone != 1 || first != LAT + 1 || r !== 32'd3) begin
      failures++;
      $display("FAIL busy_start: dones %0d at %0d res %h want 1/%0d/3",
               ndone, first, r, LAT + 1);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    int          cyc;
    run_op(32'h3F80_0000, 8'd1, r, cyc);
    dataa = 32'hC2F7_0000;
    n     = 8'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (result !== 32'hFFFF_FF85 || cyc != LAT + 1) begin
      failures++;
      $display("FAIL back_to_back: got %h lat %0d want %h lat %0d",
               result, cyc, 32'hFFFF_FF85, LAT + 1);
    end
  endtask

  task automatic test_rst_mid();
    int ndone = 0;
    @(negedge clk);
    dataa = 32'h4049_0FDB;
    n     = 8'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    checks++;
    if (done !== 1'b0 || result !== 32'd0) begin
      failures++;
      $display("FAIL rst_async: done=%b result=%h", done, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checks++;
    if (ndone != 0 || result !== 32'd0) begin
      failures++;
      $display("FAIL rst_mid: dones %0d result %h want 0/0",
               ndone, result);
    end
  endtask

  task automatic test_reset_req();
    int          ndone = 0;
    logic [31:0] r;
    int          cyc;
    run_op(32'h3F80_0000, 8'd1, r, cyc);
    @(negedge clk);
    dataa = 32'h4049_0FDB;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset_req = 1'b1;
    @(negedge clk);
    reset_req = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checks++;
    if (ndone != 0 || result !== 32'd0) begin
      failures++;
      $display("FAIL reset_req: dones %0d result %h want 0/0",
               ndone, result);
    end
    run_op(32'hC2F7_0000, 8'd1, r, cyc);
    checks++;
    if (r !== 32'hFFFF_FF85 || cyc != LAT + 1) begin
      failures++;
      $display("FAIL reset_req_idle: got %h lat %0d want %h",
               r, cyc, 32'hFFFF_FF85);
    end
  endtask

  initial begin
    test_reset();
    test_ftoi_directed();
    test_ftoi_random();
    test_itof();
    test_other_op();
    test_clk_en_stall();
    test_busy_start();
    test_back_to_back();
    test_rst_mid();
    test_reset_req();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
